iccm_fetch_align: RTL

- Fetch-side realignment stage placed directly upstream of the ICCM bank-output slice select.
- Accepts a slice-granular fetch address and issues one or two word reads to a single ICCM bank.
- Captures the returned bank data, extracts OUT_SLICES consecutive slices starting at the address offset, and presents them on a valid/ready output register.
- A fetch whose slices span two bank words costs one extra read cycle.

---
 rtl/iccm_align_pkg.sv | 28 ++
 rtl/iccm_slice_mux.sv | 27 ++
 rtl/iccm_fetch_align.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/iccm_align_pkg.sv
// Shared types and width helpers for the ICCM fetch realignment stage.
// Derived widths are computed here so the top and the slice mux always agree.
package iccm_align_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT0 = 2'd1,
    WAIT1 = 2'd2
  } fetch_state_e;

  function automatic int calc_bank_w(input int slice_w, input int slices_per_word);
    return slice_w * slices_per_word;
  endfunction

  // Slices per word is a power of two of at least 2, so this is an exact log2.
  function automatic int calc_off_w(input int slices_per_word);
    return $clog2(slices_per_word);
  endfunction

  function automatic int calc_out_w(input int slice_w, input int out_slices);
    return slice_w * out_slices;
  endfunction

  function automatic logic is_span(input int off, input int out_slices, input int slices_per_word);
    return (off + out_slices) > slices_per_word;
  endfunction

endpackage

// File: rtl/iccm_slice_mux.sv
// Combinational extraction of OUT_SLICES consecutive slices from a two-word window.
// No latency, no flow control; the hi word only contributes when span is set.
module iccm_slice_mux
  import iccm_align_pkg::*;
#(
  parameter int  SLICE_W         = 3,
  parameter int  SLICES_PER_WORD = 4,
  parameter int  OUT_SLICES      = 2,
  localparam int BANK_W          = calc_bank_w(SLICE_W, SLICES_PER_WORD),
  localparam int OFF_W           = calc_off_w(SLICES_PER_WORD),
  localparam int OUT_W           = calc_out_w(SLICE_W, OUT_SLICES)
) (
  input  logic [2*BANK_W-1:0] words,
  input  logic [OFF_W-1:0]    off,
  input  logic                span,
  output logic [OUT_W-1:0]    slices
);

  logic [2*BANK_W-1:0] window;

  always_comb begin
    // Zero the hi word when not spanning so stale bank data never leaks through.
    window = span ? words : {{BANK_W{1'b0}}, words[BANK_W-1:0]};
    slices = window[int'(off) * SLICE_W +: OUT_W];
  end

endmodule

// File: rtl/iccm_fetch_align.sv
// Fetch realignment: one or two ICCM word reads per request, aligned slices out.
// Latency 2 (in-word) or 3 (spanning); output held until out_ready, no new request meanwhile.
module iccm_fetch_align
  import iccm_align_pkg::*;
#(
  parameter int  SLICE_W         = 3,
  parameter int  SLICES_PER_WORD = 4,
  parameter int  OUT_SLICES      = 2,
  parameter int  ADDR_W          = 8,
  localparam int BANK_W          = calc_bank_w(SLICE_W, SLICES_PER_WORD),
  localparam int OFF_W           = calc_off_w(SLICES_PER_WORD),
  localparam int OUT_W           = calc_out_w(SLICE_W, OUT_SLICES),
  localparam int WORD_W          = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              bank_rd_en,
  output logic [WORD_W-1:0] bank_rd_addr,
  input  logic [BANK_W-1:0] bank_dout,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  input  logic              out_ready
);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [OFF_W-1:0]  off_q;
  logic              span_q;
  logic [WORD_W-1:0] word_q;
  logic [BANK_W-1:0] lo_q;
  logic [WORD_W-1:0] rd_addr_q;
  logic [WORD_W-1:0] rd_addr_nxt;
  logic              accept;
  logic              capture_lo;
  logic              capture_out;
  logic [BANK_W-1:0] mux_lo;
  logic [OUT_W-1:0]  mux_out;

  // Gated by rst_l so no read strobe escapes while reset is held.
  assign req_ready = rst_l && (state == IDLE) && !out_valid && !flush;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bank_rd_en  = 1'b0;
    rd_addr_nxt = rd_addr_q;
    capture_lo  = 1'b0;
    capture_out = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bank_rd_en  = 1'b1;
            rd_addr_nxt = req_addr[ADDR_W-1:OFF_W];
            state_nxt   = WAIT0;
          end
        end
        WAIT0: begin
          if (span_q) begin
            capture_lo  = 1'b1;
            bank_rd_en  = 1'b1;
            rd_addr_nxt = word_q + WORD_W'(1);
            state_nxt   = WAIT1;
          end else begin
            capture_out = 1'b1;
            state_nxt   = IDLE;
          end
        end
        WAIT1: begin
          capture_out = 1'b1;
          state_nxt   = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Address is visible in the strobe cycle and then held by rd_addr_q.
  assign bank_rd_addr = rd_addr_nxt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      off_q     <= '0;
      span_q    <= 1'b0;
      word_q    <= '0;
      lo_q      <= '0;
      rd_addr_q <= '0;
    end else begin
      rd_addr_q <= rd_addr_nxt;
      if (accept) begin
        off_q  <= req_addr[OFF_W-1:0];
        span_q <= is_span(int'(req_addr[OFF_W-1:0]), OUT_SLICES, SLICES_PER_WORD);
        word_q <= req_addr[ADDR_W-1:OFF_W];
      end
      if (capture_lo) begin
        lo_q <= bank_dout;
      end
    end
  end

  // In WAIT1 the first word was parked in lo_q and bank_dout is the second.
  assign mux_lo = (state == WAIT1) ? lo_q : bank_dout;

  iccm_slice_mux #(
    .SLICE_W         (SLICE_W),
    .SLICES_PER_WORD (SLICES_PER_WORD),
    .OUT_SLICES      (OUT_SLICES)
  ) u_slice_mux (
    .words  ({bank_dout, mux_lo}),
    .off    (off_q),
    .span   (span_q),
    .slices (mux_out)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture_out) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
